// File: rtl/flash_rd_seq.sv
// Read sequencer for the 16-bit parallel NOR flash holding the ROM image.
// Turns decoder byte/word requests into timed flash word accesses and reassembles unaligned words.
module flash_rd_seq #(
   parameter int unsigned ACC_CYCLES = 4,
   parameter logic [4:0]  PAGE       = 5'h00
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic [16:0] addr,
   input  logic        byte_m,
   input  logic        enable,
   output logic [15:0] rd_data,
   output logic        ready,
   output logic        NF_WE,
   output logic        NF_CE,
   output logic        NF_OE,
   output logic        NF_BYTE,
   output logic [21:1] NF_A,
   input  logic [15:0] NF_D
);

   typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;

   localparam logic [3:0] C_CNT_LOAD = 4'(ACC_CYCLES - 1);

   state_t      r_state, w_state_nx;
   logic [3:0]  r_cnt, w_cnt_nx;
   logic        r_ce, w_ce_nx;
   logic        r_oe, w_oe_nx;
   logic        r_ready, w_ready_nx;
   logic [15:0] r_rd_data, w_rd_data_nx;
   logic [21:1] r_nf_a, w_nf_a_nx;
   logic [16:0] r_addr, w_addr_nx;
   logic        r_byte, w_byte_nx;
   logic [15:0] r_word0, w_word0_nx;

   // Little-endian reassembly; w1 only matters for odd word reads.
   function automatic logic [15:0] f_assemble(input logic is_byte, input logic a0,
                                               input logic [15:0] w0, input logic [15:0] w1);
      logic [15:0] res;
      if (is_byte) begin
         res = {8'h00, (a0 ? w0[15:8] : w0[7:0])};
      end else if (a0) begin
         res = {w1[7:0], w0[15:8]};
      end else begin
         res = w0;
      end
      return res;
   endfunction

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= 4'h0;
         r_ce      <= 1'b1;
         r_oe      <= 1'b1;
         r_ready   <= 1'b0;
         r_rd_data <= 16'h0000;
         r_nf_a    <= {PAGE, 16'h0000};
         r_addr    <= 17'h00000;
         r_byte    <= 1'b0;
         r_word0   <= 16'h0000;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_ce      <= w_ce_nx;
         r_oe      <= w_oe_nx;
         r_ready   <= w_ready_nx;
         r_rd_data <= w_rd_data_nx;
         r_nf_a    <= w_nf_a_nx;
         r_addr    <= w_addr_nx;
         r_byte    <= w_byte_nx;
         r_word0   <= w_word0_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_ce_nx      = r_ce;
      w_oe_nx      = r_oe;
      w_ready_nx   = 1'b0;
      w_rd_data_nx = r_rd_data;
      w_nf_a_nx    = r_nf_a;
      w_addr_nx    = r_addr;
      w_byte_nx    = r_byte;
      w_word0_nx   = r_word0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_addr_nx  = addr;
               w_byte_nx  = byte_m;
               w_nf_a_nx  = {PAGE, addr[16:1]};
               w_ce_nx    = 1'b0;
               w_oe_nx    = 1'b0;
               w_cnt_nx   = C_CNT_LOAD;
               w_state_nx = RD0;
            end else begin
               w_state_nx = IDLE;
            end
         end
         RD0: begin
            if (r_cnt != 4'h0) begin
               w_cnt_nx = r_cnt - 4'h1;
            end else begin
               w_word0_nx = NF_D;
               // Odd word reads straddle two flash words; the word address wraps within the page.
               if (!r_byte && r_addr[0]) begin
                  w_nf_a_nx  = {PAGE, r_addr[16:1] + 16'h0001};
                  w_cnt_nx   = C_CNT_LOAD;
                  w_state_nx = RD1;
               end else begin
                  w_rd_data_nx = f_assemble(r_byte, r_addr[0], NF_D, 16'h0000);
                  w_ce_nx      = 1'b1;
                  w_oe_nx      = 1'b1;
                  w_ready_nx   = 1'b1;
                  w_state_nx   = DONE;
               end
            end
         end
         RD1: begin
            if (r_cnt != 4'h0) begin
               w_cnt_nx = r_cnt - 4'h1;
            end else begin
               w_rd_data_nx = f_assemble(r_byte, r_addr[0], r_word0, NF_D);
               w_ce_nx      = 1'b1;
               w_oe_nx      = 1'b1;
               w_ready_nx   = 1'b1;
               w_state_nx   = DONE;
            end
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   assign NF_WE   = 1'b1;
   assign NF_BYTE = 1'b1;
   assign NF_CE   = r_ce;
   assign NF_OE   = r_oe;
   assign NF_A    = r_nf_a;
   assign ready   = r_ready;
   assign rd_data = r_rd_data;

endmodule

// File: tb/tb_flash_rd_seq.sv
// Self-checking bench for flash_rd_seq: directed ROM reads plus randomized reads against a byte-level flash model.
module tb_flash_rd_seq;

   localparam int unsigned ACC  = 4;
   localparam logic [4:0]  PAGE = 5'h00;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic [16:0] addr;
   logic        byte_m;
   logic        enable;
   logic [15:0] rd_data;
   logic        ready;
   logic        NF_WE, NF_CE, NF_OE, NF_BYTE;
   logic [21:1] NF_A;
   logic [15:0] NF_D;

   logic [15:0] fmem [0:65535];
   int          n_checks = 0;
   int          n_pass   = 0;

   flash_rd_seq #(.ACC_CYCLES(ACC), .PAGE(PAGE)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .addr    (addr),
      .byte_m  (byte_m),
      .enable  (enable),
      .rd_data (rd_data),
      .ready   (ready),
      .NF_WE   (NF_WE),
      .NF_CE   (NF_CE),
      .NF_OE   (NF_OE),
      .NF_BYTE (NF_BYTE),
      .NF_A    (NF_A),
      .NF_D    (NF_D)
   );

   always #5 sys_clk = ~sys_clk;

   assign NF_D = fmem[NF_A[16:1]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // The ROM seen as a flat little-endian byte array.
   function automatic logic [7:0] rom_byte(input logic [16:0] b);
      logic [15:0] w;
      w = fmem[b[16:1]];
      return b[0] ? w[15:8] : w[7:0];
   endfunction

   task automatic do_read(input logic [16:0] a, input logic bm, input bit scramble,
                          input bit hold_en, output logic [15:0] got);
      logic [15:0] exp;
      int          exp_lat, lat, ce_low;
      bit          two, done;
      two     = !bm && a[0];
      exp     = bm ? {8'h00, rom_byte(a)} : {rom_byte(a + 17'h00001), rom_byte(a)};
      exp_lat = two ? 2 * ACC : ACC;
      addr    = a;
      byte_m  = bm;
      enable  = 1'b1;
      @(posedge sys_clk); #1;
      chk("nfa_first", 32'(NF_A), 32'({PAGE, a[16:1]}));
      chk("ce_oe_start", {NF_CE, NF_OE}, 32'h0);
      if (scramble) begin
         addr   = 17'($urandom);
         byte_m = 1'($urandom);
         enable = 1'($urandom);
      end
      lat    = 0;
      ce_low = 1;
      done   = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge sys_clk); #1;
         lat++;
         if (ready) begin
            done = 1'b1;
         end else begin
            if (!NF_CE && !NF_OE) ce_low++;
            if (two && lat == ACC)
               chk("nfa_second", 32'(NF_A), 32'({PAGE, a[16:1] + 16'h0001}));
         end
      end
      chk("latency", lat, exp_lat);
      chk("ce_low_cycles", ce_low, exp_lat);
      chk("rd_data", 32'(rd_data), 32'(exp));
      chk("ce_oe_done", {NF_CE, NF_OE}, 32'h3);
      got    = rd_data;
      enable = hold_en;
      @(posedge sys_clk); #1;
      chk("ready_one_cycle", 32'(ready), 32'h0);
      chk("rd_data_hold", 32'(rd_data), 32'(exp));
      chk("ce_idle", 32'(NF_CE), 32'h1);
   endtask

   initial begin
      logic [15:0] got;
      for (int i = 0; i < 65536; i++) fmem[i] = 16'($urandom);
      reset  = 1'b1;
      enable = 1'b0;
      addr   = 17'h00000;
      byte_m = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_ce_oe", {NF_CE, NF_OE}, 32'h3);
      chk("rst_nfa", 32'(NF_A), 32'({PAGE, 16'h0000}));
      chk("we_byte_tied", {NF_WE, NF_BYTE}, 32'h3);
      reset = 1'b0;
      @(posedge sys_clk); #1;

      fmem[16'hFFF8] = 16'hBEEF;
      do_read(17'h1FFF0, 1'b0, 1'b0, 1'b0, got);
      chk("tp_even_word", 32'(got), 32'h0000BEEF);

      fmem[16'h0001] = 16'h12AB;
      do_read(17'h00003, 1'b1, 1'b0, 1'b0, got);
      chk("tp_byte_hi", 32'(got), 32'h00000012);

      fmem[16'h0002] = 16'h3344;
      fmem[16'h0003] = 16'h5566;
      do_read(17'h00005, 1'b0, 1'b0, 1'b0, got);
      chk("tp_odd_word", 32'(got), 32'h00006633);

      fmem[16'hFFFF] = 16'hAA00;
      fmem[16'h0000] = 16'h00BB;
      do_read(17'h1FFFF, 1'b0, 1'b0, 1'b0, got);
      chk("tp_wrap", 32'(got), 32'h0000BBAA);

      // With enable dropped in the ready cycle, no further access may start.
      repeat (3) begin
         @(posedge sys_clk); #1;
         chk("no_spurious_ce", {NF_CE, ready}, 32'h2);
      end

      // Back-to-back requests with enable held across ready.
      do_read(17'h00010, 1'b0, 1'b0, 1'b1, got);
      do_read(17'h00021, 1'b0, 1'b0, 1'b0, got);

      // Reset during the second cycle of the second word access; the prior result is zero.
      fmem[16'h0100] = 16'h5A00;
      do_read(17'h00200, 1'b1, 1'b0, 1'b0, got);
      chk("pre_reset_value", 32'(got), 32'h0);
      addr   = 17'h00101;
      byte_m = 1'b0;
      enable = 1'b1;
      @(posedge sys_clk); #1;
      repeat (ACC + 1) @(posedge sys_clk);
      #1;
      chk("mid_rd1_ce_low", {NF_CE, NF_OE}, 32'h0);
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      chk("midrst_ce_oe", {NF_CE, NF_OE}, 32'h3);
      chk("midrst_ready", 32'(ready), 32'h0);
      chk("midrst_rd_data", 32'(rd_data), 32'h0);
      chk("midrst_nfa", 32'(NF_A), 32'({PAGE, 16'h0000}));
      @(posedge sys_clk); #1;
      reset = 1'b0;
      @(posedge sys_clk); #1;
      do_read(17'h00101, 1'b0, 1'b0, 1'b0, got);

      // Randomized reads with inputs scrambled and enable toggled mid-access.
      for (int i = 0; i < 24; i++) begin
         do_read(17'($urandom), 1'($urandom), 1'b1, 1'($urandom), got);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/flash_rd_seq.md
Name: flash_rd_seq

Overview:
- Single-clock read sequencer for the board's 16-bit parallel NOR flash (BIOS/VGA ROM image).
- Sits directly downstream of the memory address decoder. It consumes the decoder's 17-bit ROM byte address, byte/word mode and enable, and returns read data with a ready pulse.
- Drives the NF_* pins with programmable access timing.
- Splits unaligned (odd-address) word reads into two flash word accesses and reassembles the result.

Parameters:
- ACC_CYCLES, 4, flash access time in sys_clk cycles per word access (legal 1..15; 4 = 80 ns at 50 MHz).
- PAGE, 5'h00, constant driven on NF_A[21:17]; selects the 128 KB ROM window inside the flash.

Ports:
- sys_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- addr  in  17  ROM byte address; bit 16 is the segment select from the decoder.
- byte_m  in  1  1 = byte read, 0 = word read.
- enable  in  1  request; level, held by requester until ready.
- rd_data  out  16  read result.
- ready  out  1  one-cycle completion pulse.
- NF_WE  out  1  flash write enable, active-low.
- NF_CE  out  1  flash chip enable, active-low.
- NF_OE  out  1  flash output enable, active-low.
- NF_BYTE  out  1  flash bus width select.
- NF_A  out  21 ([21:1])  flash word address.
- NF_D  in  16  flash data.

Behaviour:
- Outputs:
  - NF_WE and NF_BYTE are tied 1: read-only, x16 mode.
  - All other outputs are registered.
- Reset values: rd_data=16'h0000, ready=0, NF_CE=1, NF_OE=1, NF_A={PAGE,16'h0000}, state=IDLE, counter=0.
- States: IDLE, RD0, RD1, DONE.
- IDLE:
  - If enable=1 at an edge: latch addr and byte_m, and set NF_A={PAGE, addr[16:1]}, NF_CE=0, NF_OE=0, cnt=ACC_CYCLES-1, state=RD0.
  - Otherwise hold.
- RD0 (first word access):
  - While cnt!=0: decrement.
  - At the edge with cnt==0: capture NF_D into word0.
  - If a second access is needed (byte_m=0 and addr[0]=1): set NF_A={PAGE, addr[16:1]+1}, where the 16-bit increment wraps 16'hFFFF->16'h0000; reload cnt=ACC_CYCLES-1; CE/OE stay low; state=RD1.
  - Otherwise: load rd_data, set NF_CE=1, NF_OE=1, ready=1, state=DONE.
- RD1 (second word access):
  - Same countdown as RD0.
  - At cnt==0: capture NF_D into word1, load rd_data, set CE/OE high, ready=1, state=DONE.
- DONE:
  - ready=1 for exactly this one cycle; next edge: ready=0, state=IDLE.
  - If enable is still high in the following IDLE cycle, that is a new request. The requester drops enable in the ready cycle if it wants no further access.
- Data assembly (little-endian):
  - byte_m=1: rd_data={8'h00, addr[0] ? word0[15:8] : word0[7:0]}.
  - Word, even address: rd_data=word0.
  - Word, odd address: rd_data={word1[7:0], word0[15:8]}.
- Latency from the accepting edge to ready high:
  - ACC_CYCLES cycles for single-access reads.
  - 2*ACC_CYCLES cycles for odd word reads.
  - NF_CE/NF_OE are low for exactly ACC_CYCLES or 2*ACC_CYCLES cycles, with no deassertion between RD0 and RD1.
- Boundary conditions:
  - addr/byte_m changing mid-access is ignored; the latched values are used.
  - enable dropping mid-access does not abort: the access completes and ready still pulses.
  - rd_data holds its value until the next completion.
  - ACC_CYCLES=1: RD0/RD1 last one cycle each.
  - Reset asserted mid-access: immediate return to reset values, no ready pulse, no partial rd_data update.

Test Plan:
- Reset, then enable=1, addr=17'h1FFF0, byte_m=0, flash model word 0xFFF8=16'hBEEF, ACC_CYCLES=4 -> NF_A={5'h00,16'hFFF8}; CE/OE low for 4 cycles; ready pulses at cycle 4; rd_data=16'hBEEF.
- Byte read at addr=17'h00003, word 0x0001=16'h12AB -> rd_data=16'h0012; ready after 4 cycles.
- Odd word read at addr=17'h00005, words 0x0002=16'h3344 and 0x0003=16'h5566 -> NF_A steps 0x0002 then 0x0003 with CE continuous; ready at cycle 8; rd_data=16'h6633.
- Wrap case: odd word read at addr=17'h1FFFF, words 0xFFFF=16'hAA00 and 0x0000=16'h00BB -> second NF_A=0x0000; rd_data=16'hBBAA.
- enable held high across ready with two back-to-back requests -> second access starts in the IDLE cycle after DONE; two separate ready pulses; CE high for at least 2 cycles between the accesses.
- Reset asserted in cycle 2 of RD1 -> CE/OE=1, ready=0 and rd_data keeps its pre-access value immediately; the next request completes normally.
